// File: rtl/pipe_pkg.sv
// Shared state encoding and helpers for the skid-buffered pipeline stage.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   function automatic logic [1:0] occ_of(state_e s);
      case (s)
         ST_ONE:  occ_of = 2'd1;
         ST_TWO:  occ_of = 2'd2;
         default: occ_of = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/stage_slot.sv
// One {ctrl,data} storage slot with a load enable; no reset on the datapath.
module stage_slot #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (load) q <= d;
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with registered in_ready, 2-entry skid buffer,
// flush and control-bundle squashing on bubbles.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 128,
   parameter int unsigned CTRL_W = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int unsigned SlotW = CTRL_W + DATA_W;

   state_e             state_q, state_d;
   logic               in_ready_q;
   logic [CNT_W-1:0]   stall_cnt_q;
   logic               main_load, skid_load, main_from_skid;
   logic [SlotW-1:0]   main_d, main_q, skid_q;
   logic               push, pop;

   assign out_valid = (state_q == ST_ONE) || (state_q == ST_TWO);
   assign push      = in_valid & in_ready_q;
   assign pop       = out_valid & out_ready;
   assign main_d    = main_from_skid ? skid_q : {in_ctrl, in_data};

   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      skid_load      = 1'b0;
      main_from_skid = 1'b0;
      if (reset || flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (push) begin
                  main_load = 1'b1;
                  state_d   = ST_ONE;
               end
            end
            ST_ONE: begin
               if (push && pop) begin
                  main_load = 1'b1;
               end else if (push) begin
                  skid_load = 1'b1;
                  state_d   = ST_TWO;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  state_d        = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         stall_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != ST_TWO);
         // Saturating: flush deliberately leaves the count alone.
         if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
      end
   end

   stage_slot #(.W(SlotW)) u_main (
      .clk  (clk),
      .load (main_load),
      .d    (main_d),
      .q    (main_q)
   );

   stage_slot #(.W(SlotW)) u_skid (
      .clk  (clk),
      .load (skid_load),
      .d    ({in_ctrl, in_data}),
      .q    (skid_q)
   );

   assign in_ready  = in_ready_q;
   assign out_ctrl  = out_valid ? main_q[SlotW-1 -: CTRL_W] : '0;
   assign out_data  = main_q[DATA_W-1:0];
   assign occupancy = occ_of(state_q);
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed table-driven bench for pipe_stage_skid plus stall-counter sequences.
module tb_pipe_stage_skid;

   localparam int unsigned DATA_W = 128;
   localparam int unsigned CTRL_W = 4;
   localparam int unsigned CNT_W  = 16;

   logic              clk = 1'b0;
   logic              reset, flush, in_valid, out_ready;
   logic              in_ready, out_valid;
   logic [CTRL_W-1:0] in_ctrl, out_ctrl;
   logic [DATA_W-1:0] in_data, out_data;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  stall_cnt;

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .occupancy (occupancy),
      .stall_cnt (stall_cnt)
   );

   typedef struct {
      bit       rst, fl, iv, ordy;
      bit [3:0] ictl;
      bit [7:0] idat;
      bit       eov;
      bit [3:0] ectl;
      bit [7:0] edat;
      bit       eir;
      bit [1:0] eocc;
      bit       chk_stall;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit rst, input bit fl, input bit iv, input bit ordy,
                      input bit [3:0] ictl, input bit [7:0] idat, input bit eov,
                      input bit [3:0] ectl, input bit [7:0] edat, input bit eir,
                      input bit [1:0] eocc, input bit chk_stall);
      vec_t v;
      v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.ictl = ictl; v.idat = idat;
      v.eov = eov; v.ectl = ectl; v.edat = edat; v.eir = eir; v.eocc = eocc;
      v.chk_stall = chk_stall;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic drive(input bit rst, input bit fl, input bit iv, input bit ordy,
                        input bit [3:0] ictl, input bit [7:0] idat);
      reset = rst; flush = fl; in_valid = iv; out_ready = ordy;
      in_ctrl = ictl; in_data = {120'd0, idat};
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(1, 0, 0, 0, 4'h0, 8'h00);

      // Reset two cycles.
      add(1,0,0,0, 4'h0,8'h00, 0,4'h0,8'h00, 1,2'd0, 1);
      add(1,0,1,1, 4'hF,8'h99, 0,4'h0,8'h00, 1,2'd0, 1);
      // Streaming with out_ready=1: one-cycle latency, full throughput.
      for (int i = 0; i < 5; i++) begin
         add(0,0,1,1, 4'h3,8'h11 + 8'(i), 1,4'h3,8'h11 + 8'(i), 1,2'd1, 0);
      end
      add(0,0,0,1, 4'h0,8'h00, 0,4'h0,8'h00, 1,2'd0, 0);
      // Backpressure: A,B accepted into TWO, C held, then drained in order.
      add(0,0,1,0, 4'h1,8'hA1, 1,4'h1,8'hA1, 1,2'd1, 0);
      add(0,0,1,0, 4'h2,8'hB2, 1,4'h1,8'hA1, 0,2'd2, 0);
      add(0,0,1,0, 4'h4,8'hC3, 1,4'h1,8'hA1, 0,2'd2, 0);
      add(0,0,1,1, 4'h4,8'hC3, 1,4'h2,8'hB2, 1,2'd1, 0);
      add(0,0,1,1, 4'h4,8'hC3, 1,4'h4,8'hC3, 1,2'd1, 0);
      add(0,0,0,1, 4'h0,8'h00, 0,4'h0,8'h00, 1,2'd0, 0);
      // Flush in TWO while offering D; D must never appear.
      add(0,0,1,0, 4'hF,8'hE1, 1,4'hF,8'hE1, 1,2'd1, 0);
      add(0,0,1,0, 4'hF,8'hE2, 1,4'hF,8'hE1, 0,2'd2, 0);
      add(0,1,1,0, 4'hF,8'hDD, 0,4'h0,8'h00, 1,2'd0, 0);
      add(0,0,0,1, 4'h0,8'h00, 0,4'h0,8'h00, 1,2'd0, 0);
      // Flush in ONE with in_ready=1: offered entry still discarded.
      add(0,0,1,0, 4'hF,8'hF1, 1,4'hF,8'hF1, 1,2'd1, 0);
      add(0,1,1,1, 4'hF,8'hDD, 0,4'h0,8'h00, 1,2'd0, 0);
      add(0,0,0,1, 4'h0,8'h00, 0,4'h0,8'h00, 1,2'd0, 0);
      // Reset from TWO with out_ready toggling, then first push after 1 cycle.
      add(0,0,1,0, 4'h5,8'h51, 1,4'h5,8'h51, 1,2'd1, 0);
      add(0,0,1,0, 4'h6,8'h62, 1,4'h5,8'h51, 0,2'd2, 0);
      add(0,0,0,1, 4'h0,8'h00, 1,4'h6,8'h62, 1,2'd1, 0);
      add(0,0,1,0, 4'h7,8'h73, 1,4'h6,8'h62, 0,2'd2, 0);
      add(1,0,1,1, 4'h8,8'h84, 0,4'h0,8'h00, 1,2'd0, 1);
      add(0,0,1,1, 4'h9,8'h77, 1,4'h9,8'h77, 1,2'd1, 0);
      add(0,0,0,1, 4'h0,8'h00, 0,4'h0,8'h00, 1,2'd0, 0);

      foreach (vecs[i]) begin
         vec_t v;
         v = vecs[i];
         drive(v.rst, v.fl, v.iv, v.ordy, v.ictl, v.idat);
         step();
         chk($sformatf("v%0d out_valid", i), 128'(out_valid), 128'(v.eov));
         chk($sformatf("v%0d out_ctrl", i), 128'(out_ctrl), 128'(v.ectl));
         chk($sformatf("v%0d in_ready", i), 128'(in_ready), 128'(v.eir));
         chk($sformatf("v%0d occupancy", i), 128'(occupancy), 128'(v.eocc));
         if (v.eov) chk($sformatf("v%0d out_data", i), out_data, {120'd0, v.edat});
         if (v.chk_stall) chk($sformatf("v%0d stall_cnt", i), 128'(stall_cnt), 128'd0);
      end

      // Stall counter: exact count, saturation, kept by flush, cleared by reset.
      drive(1, 0, 0, 0, 4'h0, 8'h00);
      step();
      drive(0, 0, 1, 0, 4'h1, 8'h42);
      step();
      chk("stall start", 128'(stall_cnt), 128'd0);
      drive(0, 0, 0, 0, 4'h0, 8'h00);
      repeat (5) step();
      chk("stall count5", 128'(stall_cnt), 128'd5);
      chk("stall hold data", out_data, 128'h42);
      repeat (70000) @(posedge clk);
      #1;
      chk("stall saturate", 128'(stall_cnt), 128'hFFFF);
      drive(0, 1, 0, 0, 4'h0, 8'h00);
      step();
      chk("stall after flush", 128'(stall_cnt), 128'hFFFF);
      chk("flush out_valid", 128'(out_valid), 128'd0);
      drive(1, 0, 0, 0, 4'h0, 8'h00);
      step();
      chk("stall after reset", 128'(stall_cnt), 128'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
